// File: rtl/calc_cmd_scheduler.sv
// rtl/calc_cmd_scheduler.sv - keypad code FIFO and one-at-a-time command issue to the calculator core
// Optional busy watchdog enabled by defining CALC_SCHED_TIMEOUT_EN.
module calc_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    output logic                     key_ready,
    input  logic [1:0]               calc_status,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic [1:0]               err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_HALT
    } state_t;

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          calc_err;

    assign full      = (fifo_count == FULL_CNT);
    assign key_ready = !full && (state != S_HALT);
    assign push      = key_valid && key_ready;
    assign calc_err  = (calc_status == ST_ERROR) && (state != S_HALT);
    // An error in the ISSUE cycle aborts the issue, so nothing is popped.
    assign pop       = (state == S_ISSUE) && !calc_err;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

`ifdef CALC_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wdog;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 2'b00;
`ifdef CALC_SCHED_TIMEOUT_EN
            wdog       <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);

            case (state)
                S_IDLE: begin
                    if (fifo_count != '0 && calc_status == ST_READY) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
`ifdef CALC_SCHED_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    cmd       <= mem[rd_ptr];
                    cmd_valid <= 1'b1;
                    state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (calc_status == ST_BUSY) begin
                        state <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    if (calc_status == ST_READY) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase

`ifdef CALC_SCHED_TIMEOUT_EN
            if (state == S_WAIT_BUSY || state == S_WAIT_READY) begin
                wdog <= wdog + 1'b1;
                if (wdog == WW'(TIMEOUT - 1)) begin
                    state      <= S_HALT;
                    busy       <= 1'b0;
                    err        <= 2'b10;
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    fifo_count <= '0;
                end
            end
`endif

            // Calculator error overrides every other transition, including the watchdog.
            if (calc_err) begin
                state      <= S_HALT;
                busy       <= 1'b0;
                err        <= 2'b01;
                cmd_valid  <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// tb/tb_calc_cmd_scheduler.sv - scoreboard bench for calc_cmd_scheduler
module tb_calc_cmd_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready;
    logic [1:0] calc_status = 2'b01;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [3:0] fifo_count;
    logic       busy;
    logic [1:0] err;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_cyc = -1;
    logic       model_en = 1'b0;
    logic [3:0] sb [$];

    calc_cmd_scheduler #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every cmd_valid pulse must match the next expected code.
    always @(negedge clock) begin
        if (reset_n && cmd_valid) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_cmd_valid: got cmd=%0d expected no issue", cmd);
            end else begin
                logic [3:0] exp_code;
                exp_code = sb.pop_front();
                if (cmd !== exp_code) begin
                    errors = errors + 1;
                    $display("FAIL cmd_value: got %0d expected %0d", cmd, exp_code);
                end
            end
            if (last_cyc >= 0) check("cmd_spacing_ge4", (cyc - last_cyc >= 4) ? 1 : 0, 1);
            last_cyc = cyc;
        end
    end

    // Calculator model: busy one cycle after a command, ready again two cycles later.
    always @(negedge clock) begin
        if (model_en && cmd_valid) begin
            @(posedge clock); #1 calc_status = 2'b01;
            repeat (2) @(posedge clock);
            #1 calc_status = 2'b10;
        end
    end

    task automatic do_reset();
        model_en  = 1'b0;
        key_valid = 1'b0;
        reset_n   = 1'b0;
        sb.delete();
        last_cyc  = -1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic push_code(input logic [3:0] code);
        int budget;
        budget = 50;
        key_valid = 1'b1;
        key_code  = code;
        while (!key_ready && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (budget == 0) check("push_timeout", 0, 1);
        @(posedge clock); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_cmd_valid();
        int budget;
        budget = 30;
        do begin
            @(posedge clock); #1;
            budget--;
        end while (!cmd_valid && budget > 0);
        if (!cmd_valid) check("wait_cmd_valid_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 300;
        while (!(fifo_count == 0 && !busy && sb.size() == 0) && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        check("drain_done", (budget > 0) ? 1 : 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [3:0] t2_codes [4];
        t2_codes = '{4'd5, 4'd10, 4'd3, 4'd14};

        // Reset values, start-up with calculator busy
        calc_status = 2'b01;
        do_reset();
        check("rst_cmd", cmd, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_key_ready", key_ready, 1);

        push_code(4'd7);
        push_code(4'd2);
        push_code(4'd9);
        repeat (3) @(posedge clock);
        #1;
        check("t1_count3", fifo_count, 3);
        sb.push_back(4'd7); sb.push_back(4'd2); sb.push_back(4'd9);
        model_en = 1'b1;
        calc_status = 2'b10;
        repeat (2) @(posedge clock);
        #1;
        check("t1_latency_valid", cmd_valid, 1);
        check("t1_latency_cmd", cmd, 7);
        wait_drain();

        // Back-to-back stream through the calculator model
        do_reset();
        model_en = 1'b1;
        calc_status = 2'b10;
        foreach (t2_codes[i]) sb.push_back(t2_codes[i]);
        foreach (t2_codes[i]) push_code(t2_codes[i]);
        wait_drain();
        check("t2_final_count", fifo_count, 0);
        check("t2_last_cmd", cmd, 14);

        // Full FIFO backpressure
        calc_status = 2'b01;
        do_reset();
        for (int i = 1; i <= 8; i++) push_code(4'(i));
        check("t3_full_count", fifo_count, 8);
        check("t3_full_key_ready", key_ready, 0);
        key_valid = 1'b1;
        key_code  = 4'd6;
        repeat (3) @(posedge clock);
        #1;
        check("t3_held_not_accepted", fifo_count, 8);
        sb.push_back(4'd1);
        calc_status = 2'b10;
        wait_cmd_valid();
        calc_status = 2'b01;
        check("t3_after_pop_count", fifo_count, 7);
        check("t3_after_pop_ready", key_ready, 1);
        @(posedge clock); #1;
        key_valid = 1'b0;
        check("t3_ninth_accepted", fifo_count, 8);

        // Calculator error during WAIT_READY
        calc_status = 2'b01;
        do_reset();
        push_code(4'd1);
        push_code(4'd2);
        push_code(4'd3);
        sb.push_back(4'd1);
        calc_status = 2'b10;
        wait_cmd_valid();
        calc_status = 2'b01;
        repeat (2) @(posedge clock);
        #1;
        check("t4_busy_wait_ready", busy, 1);
        check("t4_queued2", fifo_count, 2);
        calc_status = 2'b00;
        @(posedge clock); #1;
        calc_status = 2'b10;
        check("t4_err", err, 1);
        check("t4_flushed", fifo_count, 0);
        check("t4_key_ready", key_ready, 0);
        check("t4_busy", busy, 0);
        key_valid = 1'b1;
        key_code  = 4'd4;
        repeat (20) @(posedge clock);
        #1;
        key_valid = 1'b0;
        check("t4_halt_no_push", fifo_count, 0);
        check("t4_halt_err_held", err, 1);
        do_reset();
        check("t4_reset_err", err, 0);
        check("t4_reset_key_ready", key_ready, 1);

        // Watchdog (or its absence)
        calc_status = 2'b01;
        do_reset();
        push_code(4'd9);
        sb.push_back(4'd9);
        calc_status = 2'b10;
        wait_cmd_valid();
        calc_status = 2'b01;
`ifdef CALC_SCHED_TIMEOUT_EN
        repeat (15) @(posedge clock);
        #1;
        check("t5_wdog_not_yet", err, 0);
        @(posedge clock); #1;
        check("t5_wdog_err", err, 2);
        check("t5_wdog_flush", fifo_count, 0);
`else
        repeat (1000) @(posedge clock);
        #1;
        check("t5_no_wdog_err", err, 0);
        check("t5_no_wdog_busy", busy, 1);
`endif

        // Asynchronous reset in WAIT_BUSY
        calc_status = 2'b01;
        do_reset();
        for (int i = 1; i <= 4; i++) push_code(4'(i + 10));
        sb.push_back(4'd11);
        calc_status = 2'b10;
        wait_cmd_valid();
        @(posedge clock); #1;
        check("t6_busy_before", busy, 1);
        check("t6_count_before", fifo_count, 3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cmd", cmd, 0);
        check("t6_rst_cmd_valid", cmd_valid, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_key_ready", key_ready, 1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("sb_empty_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
